// File: rtl/llac_common_pkg.sv
// ---------------------------------------------------------------------------
// llac_common_pkg
//
// Shared definitions for the level/edge capture blocks.
//
// Contents:
//   edge_mode_t  - two-bit per-channel edge select (off / rise / fall / both)
//   MODE_*       - raw encodings of the same values, for code that handles
//                  packed mode vectors without casting
//   edge_qualify - turns raw rise/fall indications into an event according
//                  to an edge_mode_t selection
// ---------------------------------------------------------------------------
package llac_common_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Event qualification: an edge counts only if the mode selects it.
  function automatic logic edge_qualify(input edge_mode_t mode,
                                        input logic       rise,
                                        input logic       fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// ---------------------------------------------------------------------------
// edge_det_chan
//
// One edge-detect channel: synchroniser, debounce filter, edge detector,
// sticky flag and saturating event counter.
//
// Parameters:
//   SYNC_STAGES - synchroniser depth (>= 2)
//   DB_CYCLES   - cycles the synchronised level must disagree with the
//                 debounced level before the debounced level follows it
//                 (0 = no filtering, debounced level tracks the synchroniser)
//   CNT_W       - event counter width
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   sig    in   raw asynchronous level input
//   mode   in   edge select (edge_mode_t encoding)
//   clr    in   one-cycle strobe clearing flag and counter
//   pe     out  registered one-cycle event pulse
//   flag   out  sticky event flag
//   cnt    out  saturating event count
// ---------------------------------------------------------------------------
module edge_det_chan
  import llac_common_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             pe,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_level;
  logic                   db_level;
  logic                   db_prev_reg;
  logic                   rise;
  logic                   fall;
  logic                   pe_next;
  logic                   pe_reg;
  logic                   flag_reg;
  logic [CNT_W-1:0]       cnt_reg;

  // Synchroniser: the only logic that ever looks at the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig};
    end
  end

  assign sync_level = sync_reg[SYNC_STAGES-1];

  // Debounce filter.
  generate
    if (DB_CYCLES == 0) begin : g_db_bypass
      assign db_level = sync_level;
    end else begin : g_db
      localparam int              DB_W    = $clog2(DB_CYCLES + 1);
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

      logic [DB_W-1:0] db_cnt_reg;
      logic            db_level_reg;

      // The counter counts consecutive disagreeing cycles. On the
      // DB_CYCLES-th one the level flips, so the flip lands exactly
      // DB_CYCLES edges after the synchroniser first presented it.
      // Any agreeing cycle restarts qualification from zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt_reg   <= '0;
          db_level_reg <= 1'b0;
        end else if (sync_level == db_level_reg) begin
          db_cnt_reg   <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          db_cnt_reg   <= '0;
          db_level_reg <= sync_level;
        end else begin
          db_cnt_reg   <= db_cnt_reg + 1'b1;
        end
      end

      assign db_level = db_level_reg;
    end
  endgenerate

  // Edge detection always follows the debounced level, independent of the
  // mode, so changing the mode never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_reg <= 1'b0;
    end else begin
      db_prev_reg <= db_level;
    end
  end

  assign rise    = db_level & ~db_prev_reg;
  assign fall    = ~db_level & db_prev_reg;
  assign pe_next = edge_qualify(edge_mode_t'(mode), rise, fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_reg <= 1'b0;
    end else begin
      pe_reg <= pe_next;
    end
  end

  // Flag and counter update on the cycle after the pulse. A clear that
  // lands on that same cycle restarts from the new event instead of
  // dropping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (clr) begin
      flag_reg <= pe_reg;
      cnt_reg  <= pe_reg ? CNT_ONE : '0;
    end else if (pe_reg) begin
      flag_reg <= 1'b1;
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pe   = pe_reg;
  assign flag = flag_reg;
  assign cnt  = cnt_reg;

endmodule

// File: rtl/edge_det_bank.sv
// ---------------------------------------------------------------------------
// edge_det_bank
//
// Bank of N_CH independent edge detectors with per-channel debounce, sticky
// flags, saturating event counters and a masked interrupt summary.
//
// Parameters:
//   N_CH        - number of channels (1..32)
//   SYNC_STAGES - synchroniser depth (>= 2)
//   DB_CYCLES   - debounce qualification length (0 = bypass)
//   CNT_W       - width of each per-channel event counter
//
// Ports:
//   clk     in   clock for all logic
//   rst_n   in   asynchronous active-low reset
//   sig_i   in   [N_CH]        raw asynchronous level inputs
//   mode_i  in   [2*N_CH]      per-channel edge select, channel i at [2i+:2]
//   mask_i  in   [N_CH]        per-channel interrupt enable
//   clr_i   in   [N_CH]        per-channel flag/counter clear strobe
//   pe_o    out  [N_CH]        one-cycle event pulses
//   flag_o  out  [N_CH]        sticky event flags
//   cnt_o   out  [N_CH*CNT_W]  event counts, channel i at [i*CNT_W+:CNT_W]
//   irq_o   out                OR of enabled flags
// ---------------------------------------------------------------------------
module edge_det_bank
  import llac_common_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       sig_i,
  input  logic [2*N_CH-1:0]     mode_i,
  input  logic [N_CH-1:0]       mask_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       pe_o,
  output logic [N_CH-1:0]       flag_o,
  output logic [N_CH*CNT_W-1:0] cnt_o,
  output logic                  irq_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      edge_det_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig_i[gi]),
        .mode  (mode_i[2*gi +: 2]),
        .clr   (clr_i[gi]),
        .pe    (pe_o[gi]),
        .flag  (flag_o[gi]),
        .cnt   (cnt_o[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Mask only gates the summary; flags stay set underneath it, so raising a
  // mask bit reports an already-pending event in the same cycle.
  assign irq_o = |(flag_o & mask_i);

endmodule

// File: tb/tb_edge_det_bank.sv
// ---------------------------------------------------------------------------
// tb_edge_det_bank
//
// Directed bench for edge_det_bank. Main instance: 8 channels, 2-stage sync,
// 4-cycle debounce, 4-bit counters. Second instance: 1 channel, debounce
// bypassed. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_edge_det_bank;
  import llac_common_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sig_i;
  logic [15:0] mode_i;
  logic [7:0]  mask_i;
  logic [7:0]  clr_i;
  logic [7:0]  pe_o;
  logic [7:0]  flag_o;
  logic [31:0] cnt_o;
  logic        irq_o;

  logic [0:0]  b_sig;
  logic [1:0]  b_mode;
  logic [0:0]  b_mask;
  logic [0:0]  b_clr;
  logic [0:0]  b_pe;
  logic [0:0]  b_flag;
  logic [7:0]  b_cnt;
  logic        b_irq;

  int n_err;
  int n_chk;
  int npe [8];

  edge_det_bank #(
    .N_CH(8), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_i), .mode_i(mode_i),
    .mask_i(mask_i), .clr_i(clr_i), .pe_o(pe_o), .flag_o(flag_o),
    .cnt_o(cnt_o), .irq_o(irq_o)
  );

  edge_det_bank #(
    .N_CH(1), .SYNC_STAGES(2), .DB_CYCLES(0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_i(b_sig), .mode_i(b_mode),
    .mask_i(b_mask), .clr_i(b_clr), .pe_o(b_pe), .flag_o(b_flag),
    .cnt_o(b_cnt), .irq_o(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n cycles, tallying pulses per channel.
  task automatic tick_count(input int n);
    repeat (n) begin
      tick(1);
      for (int c = 0; c < 8; c++) if (pe_o[c]) npe[c]++;
    end
  endtask

  task automatic set_mode(input int ch, input edge_mode_t m);
    mode_i[2*ch +: 2] = m;
  endtask

  function automatic logic [3:0] cnt_of(input int ch);
    return cnt_o[ch*4 +: 4];
  endfunction

  initial begin
    n_err = 0;
    n_chk = 0;
    for (int c = 0; c < 8; c++) npe[c] = 0;
    rst_n = 1'b0; sig_i = '0; mode_i = '0; mask_i = '0; clr_i = '0;
    b_sig = '0; b_mode = '0; b_mask = '0; b_clr = '0;

    // Reset state
    tick(3);
    chk("rst_pe",   pe_o,   32'h0);
    chk("rst_flag", flag_o, 32'h0);
    chk("rst_cnt",  cnt_o,  32'h0);
    chk("rst_irq",  irq_o,  32'h0);
    rst_n = 1'b1;
    tick(2);

    // Single rise on ch0: pulse on the 7th edge after the change
    set_mode(0, EDGE_RISE);
    mask_i[0] = 1'b1;
    sig_i[0]  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("ch0_pe_e%0d", k), pe_o, (k == 7) ? 32'h01 : 32'h00);
    end
    chk("ch0_flag", flag_o,    32'h01);
    chk("ch0_cnt",  cnt_of(0), 32'h1);
    chk("ch0_irq",  irq_o,     32'h1);

    // 3-cycle glitch on ch1 is rejected
    set_mode(1, EDGE_RISE);
    sig_i[1] = 1'b1;
    tick(3);
    sig_i[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk("glitch_pe", pe_o, 32'h00);
    end
    chk("glitch_flag", flag_o,    32'h01);
    chk("glitch_cnt",  cnt_of(1), 32'h0);

    // 5 pulses of 10 high / 10 low: ch2 both edges, ch3 fall only
    set_mode(2, EDGE_BOTH);
    set_mode(3, EDGE_FALL);
    for (int p = 0; p < 5; p++) begin
      sig_i[3:2] = 2'b11;
      tick_count(10);
      sig_i[3:2] = 2'b00;
      tick_count(10);
    end
    tick_count(10);
    chk("both_npe",  npe[2],    32'd10);
    chk("both_cnt",  cnt_of(2), 32'd10);
    chk("fall_npe",  npe[3],    32'd5);
    chk("fall_cnt",  cnt_of(3), 32'd5);
    chk("pulse_flag", flag_o,   32'h0D);

    // Clear ch0 alone; masking behaviour with pending flags on ch2/ch3
    clr_i[0] = 1'b1;
    tick(1);
    clr_i[0] = 1'b0;
    chk("clr_flag", flag_o,    32'h0C);
    chk("clr_cnt",  cnt_of(0), 32'h0);
    chk("mask0_irq", irq_o,    32'h0);
    mask_i[2] = 1'b1;
    #1;
    chk("mask_up_irq", irq_o, 32'h1);
    mask_i[2] = 1'b0;
    #1;
    chk("mask_dn_irq",  irq_o,  32'h0);
    chk("mask_dn_flag", flag_o, 32'h0C);

    // Saturation: 20 events on ch4 with a 4-bit counter
    set_mode(4, EDGE_BOTH);
    for (int c = 0; c < 8; c++) npe[c] = 0;
    for (int p = 0; p < 10; p++) begin
      sig_i[4] = 1'b1;
      tick_count(6);
      sig_i[4] = 1'b0;
      tick_count(6);
    end
    tick_count(10);
    chk("sat_npe", npe[4],    32'd20);
    chk("sat_cnt", cnt_of(4), 32'd15);

    // Clear coincident with flag-set: event wins
    sig_i[4] = 1'b1;
    tick(7);
    chk("coinc_pe", pe_o, 32'h10);
    clr_i[4] = 1'b1;
    tick(1);
    clr_i[4] = 1'b0;
    chk("coinc_flag", flag_o[4], 32'h1);
    chk("coinc_cnt",  cnt_of(4), 32'h1);

    // Level tracked while mode is off; enabling afterwards creates no event
    sig_i[5] = 1'b1;
    tick(10);
    set_mode(5, EDGE_BOTH);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk("mode_chg_pe", pe_o, 32'h00);
    end
    chk("mode_chg_flag", flag_o[5], 32'h0);

    // Input held high through reset yields exactly one rise
    mask_i = 8'hFF;
    #1;
    chk("pre_rst_irq", irq_o, 32'h1);
    sig_i = 8'h40;
    set_mode(6, EDGE_RISE);
    rst_n = 1'b0;
    #1;
    chk("rst1_pe",   pe_o,   32'h0);
    chk("rst1_flag", flag_o, 32'h0);
    chk("rst1_cnt",  cnt_o,  32'h0);
    chk("rst1_irq",  irq_o,  32'h0);
    tick(3);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      chk($sformatf("rel_pe_e%0d", k), pe_o, (k == 7) ? 32'h40 : 32'h00);
    end
    chk("rel_flag", flag_o,    32'h40);
    chk("rel_cnt",  cnt_of(6), 32'h1);
    chk("rel_irq",  irq_o,     32'h1);

    // Reset in the middle of a fall qualification: nothing survives
    set_mode(6, EDGE_BOTH);
    sig_i[6] = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("rst2_pe",   pe_o,   32'h0);
    chk("rst2_flag", flag_o, 32'h0);
    chk("rst2_cnt",  cnt_o,  32'h0);
    chk("rst2_irq",  irq_o,  32'h0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk("stale_pe", pe_o, 32'h00);
    end
    chk("stale_flag", flag_o, 32'h0);

    // Debounce bypassed: pulse on the 3rd edge after the change
    b_mode = MODE_RISE;
    b_sig  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("byp_pe_e%0d", k), b_pe, (k == 3) ? 32'h1 : 32'h0);
    end
    chk("byp_flag", b_flag, 32'h1);
    chk("byp_cnt",  b_cnt,  32'h1);
    b_mask = 1'b1;
    #1;
    chk("byp_irq", b_irq, 32'h1);
    b_sig = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("byp_fall_pe", b_pe, 32'h0);
    end
    chk("byp_cnt2", b_cnt, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/edge_det_bank.md
EDGE_DET_BANK -- requirements
Module: edge_det_bank

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flop depth (minimum 2).
REQ-003 SHALL have parameter DB_CYCLES, default 4, debounce qualification length in clk cycles (0 = debounce bypassed).
REQ-004 SHALL have parameter CNT_W, default 8, width of each per-channel event counter.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port sig_i  input  N_CH  raw asynchronous level inputs.
REQ-008 SHALL have port mode_i  input  2*N_CH  per-channel edge select: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port mask_i  input  N_CH  per-channel interrupt enable.
REQ-010 SHALL have port clr_i  input  N_CH  per-channel clear of flag and counter, one-cycle strobe.
REQ-011 SHALL have port pe_o  output  N_CH  registered one-cycle event pulse per channel.
REQ-012 SHALL have port flag_o  output  N_CH  sticky event flag per channel.
REQ-013 SHALL have port cnt_o  output  N_CH*CNT_W  per-channel saturating event count, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port irq_o  output  1  OR of (flag_o & mask_i).

Function
REQ-015 SHALL pass each sig_i bit through a SYNC_STAGES-deep flop chain; no other logic SHALL sample sig_i.
REQ-016 SHALL hold a per-channel debounced level; a per-channel counter increments while the synchronised level differs from the debounced level; the debounced level SHALL flip when the counter reaches DB_CYCLES.
REQ-017 SHALL reset the debounce counter to 0 on any cycle where synchronised and debounced levels agree (glitches shorter than DB_CYCLES are rejected).
REQ-018 SHALL, with DB_CYCLES = 0, make the debounced level equal the synchronised level.
REQ-019 SHALL detect a rise as debounced 0->1 and a fall as debounced 1->0, qualified by mode_i.
REQ-020 SHALL assert pe_o[i] for exactly one cycle per qualified edge, SYNC_STAGES + DB_CYCLES + 1 rising clk edges after the first edge that samples the new sig_i level.
REQ-021 SHALL track the debounced level regardless of mode; a mode_i change SHALL take effect on the next cycle and SHALL NOT itself create an event.
REQ-022 SHALL set flag_o[i] on the cycle after pe_o[i] is asserted, holding it until clr_i[i].
REQ-023 SHALL increment cnt_o channel i on each pe_o[i]; the counter SHALL saturate at 2^CNT_W-1.
REQ-024 SHALL, when clr_i[i] coincides with a flag-set, leave flag_o[i]=1 and count=1 (event wins, never lost).
REQ-025 SHALL drive irq_o combinationally from registered flag_o and mask_i; masking SHALL NOT clear flags.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear synchronisers, debounced levels, debounce counters, pe_o, flag_o, cnt_o; irq_o reads 0.
REQ-027 SHALL, since the debounced level resets to 0, produce one rise event for an input held high across reset release (documented behaviour).
REQ-028 SHALL, on reset mid-debounce, discard partial qualification; no pulse follows from pre-reset activity except per REQ-027.

Structure
REQ-029 SHALL place edge_mode_t (OFF, RISE, FALL, BOTH) and the mode encodings in shared package llac_common_pkg.
REQ-030 SHALL implement one channel (synchroniser, debounce, detect, flag, counter) as sub-module edge_det_chan, instantiated N_CH times by generate.
REQ-031 SHALL keep irq_o reduction and port packing in the top level only.

Verification
REQ-032 SHALL cover: N_CH=8, DB=4, mode=01, sig_i[0] 0->1 held -> single pe_o[0] at edge 7, flag_o[0]=1, cnt=1, irq_o=1 with mask_i[0]=1.
REQ-033 SHALL cover: 3-cycle high glitch on sig_i[1], DB=4 -> no pe_o, flag, or count change.
REQ-034 SHALL cover: mode=11, 5 full pulses of 10-cycle high/10-cycle low -> 10 pe_o pulses, cnt=10; mode=10 -> 5.
REQ-035 SHALL cover: CNT_W=4, 20 events -> cnt saturates at 15; clr_i on same cycle as a flag-set -> flag=1, cnt=1.
REQ-036 SHALL cover: sig_i high during reset, rst_n released -> exactly one rise pulse; rst_n asserted mid-debounce -> all outputs 0 immediately, no stale pulse.
REQ-037 SHALL cover: mask_i=0 with events -> irq_o=0, flag_o set; raising mask_i -> irq_o=1 same cycle.
